qrow_max_select: RTL and testbench



---
 rtl/qrow_max_select.sv | 158 +++++++++++++++
 tb/tb_qrow_max_select.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qrow_max_select.sv
// Streams one Q-table row, tracks the signed greedy max and the explore candidate,
// and reports the chosen action, its Q value and the reward for (state, action).
module qrow_max_select #(
  parameter int          NUM_STATES  = 36,
  parameter int          NUM_ACTIONS = 4,
  parameter int          Q_W         = 16,
  parameter int          R_W         = 8,
  parameter int          GOAL_S0     = 35,
  parameter int          GOAL_A0     = 1,
  parameter int          GOAL_S1     = 30,
  parameter int          GOAL_A1     = 0,
  parameter int          REWARD_VAL  = 10,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int         S_W         = $clog2(NUM_STATES),
  localparam int         A_W         = $clog2(NUM_ACTIONS),
  localparam int         QA_W        = $clog2(NUM_STATES * NUM_ACTIONS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [S_W-1:0]  state,
  input  logic            explore,
  output logic            q_rd_en,
  output logic [QA_W-1:0] q_rd_addr,
  input  logic [Q_W-1:0]  q_rd_data,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [Q_W-1:0]  max_q,
  output logic [A_W-1:0]  max_act,
  output logic [A_W-1:0]  act,
  output logic [Q_W-1:0]  act_q,
  output logic [R_W-1:0]  reward
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} fsm_t;

  fsm_t            r_fsm, w_fsm_nxt;
  logic [S_W-1:0]  r_state;
  logic            r_explore, r_err;
  logic [A_W-1:0]  r_rnd, r_idx, r_cap_idx, r_max_act;
  logic            r_cap_vld;
  logic [Q_W-1:0]  r_max_q, r_exp_q;
  logic [15:0]     r_lfsr;
  logic            r_done, r_err_o;
  logic [Q_W-1:0]  r_max_q_o, r_act_q_o;
  logic [A_W-1:0]  r_max_act_o, r_act_o;
  logic [R_W-1:0]  r_reward_o;

  logic            w_bad_state, w_last_rd, w_goal;
  logic [A_W:0]    w_rnd_ext;
  logic [A_W-1:0]  w_rnd, w_act;
  logic [Q_W-1:0]  w_act_q;

  assign w_bad_state = {1'b0, state} >= (S_W+1)'(NUM_STATES);
  assign w_last_rd   = r_idx == A_W'(NUM_ACTIONS - 1);
  assign w_rnd_ext   = {1'b0, r_lfsr[A_W-1:0]};
  assign w_rnd       = (w_rnd_ext >= (A_W+1)'(NUM_ACTIONS))
                       ? A_W'(w_rnd_ext - (A_W+1)'(NUM_ACTIONS)) : r_lfsr[A_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (start) w_fsm_nxt = w_bad_state ? S_DONE : S_READ;
      S_READ:  if (w_last_rd) w_fsm_nxt = S_DRAIN;
      S_DRAIN: w_fsm_nxt = S_DONE;
      S_DONE:  w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    q_rd_en   = r_fsm == S_READ;
    busy      = r_fsm != S_IDLE;
    q_rd_addr = QA_W'(r_state) * QA_W'(NUM_ACTIONS) + QA_W'(r_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  // Read data trails the strobe by one cycle, so the index is delayed alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= '0;
      r_explore <= 1'b0;
      r_err     <= 1'b0;
      r_rnd     <= '0;
      r_idx     <= '0;
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
      r_max_q   <= '0;
      r_max_act <= '0;
      r_exp_q   <= '0;
    end else begin
      r_cap_vld <= q_rd_en;
      r_cap_idx <= r_idx;
      if (r_fsm == S_IDLE && start) begin
        r_state   <= state;
        r_explore <= explore;
        r_err     <= w_bad_state;
        r_rnd     <= w_rnd;
        r_idx     <= '0;
      end else if (r_fsm == S_READ) begin
        r_idx <= r_idx + 1'b1;
      end
      if (r_cap_vld) begin
        if (r_cap_idx == '0 || $signed(q_rd_data) > $signed(r_max_q)) begin
          r_max_q   <= q_rd_data;
          r_max_act <= r_cap_idx;
        end
        if (r_cap_idx == r_rnd) r_exp_q <= q_rd_data;
      end
    end
  end

  assign w_act   = r_explore ? r_rnd : r_max_act;
  assign w_act_q = r_explore ? r_exp_q : r_max_q;
  assign w_goal  = (r_state == S_W'(GOAL_S0) && w_act == A_W'(GOAL_A0)) ||
                   (r_state == S_W'(GOAL_S1) && w_act == A_W'(GOAL_A1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done      <= 1'b0;
      r_err_o     <= 1'b0;
      r_max_q_o   <= '0;
      r_max_act_o <= '0;
      r_act_o     <= '0;
      r_act_q_o   <= '0;
      r_reward_o  <= '0;
    end else begin
      r_done <= r_fsm == S_DONE;
      if (r_fsm == S_DONE) begin
        r_err_o     <= r_err;
        r_max_q_o   <= r_err ? '0 : r_max_q;
        r_max_act_o <= r_err ? '0 : r_max_act;
        r_act_o     <= r_err ? '0 : w_act;
        r_act_q_o   <= r_err ? '0 : w_act_q;
        r_reward_o  <= (!r_err && w_goal) ? R_W'(REWARD_VAL) : '0;
      end
    end
  end

  assign done    = r_done;
  assign err     = r_err_o;
  assign max_q   = r_max_q_o;
  assign max_act = r_max_act_o;
  assign act     = r_act_o;
  assign act_q   = r_act_q_o;
  assign reward  = r_reward_o;

endmodule

// File: tb/tb_qrow_max_select.sv
// Bench for qrow_max_select: transaction-level model predicting every output each
// cycle, directed scenarios with literal expectations, then randomized operations.
module tb_qrow_max_select;
  localparam int NS  = 36;
  localparam int NA  = 4;
  localparam int QW  = 16;
  localparam int RW  = 8;
  localparam int SW  = $clog2(NS);
  localparam int AW  = $clog2(NA);
  localparam int QAW = $clog2(NS * NA);
  localparam logic [15:0] SEED = 16'hACE1;

  logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0, explore = 1'b0;
  logic [SW-1:0]   state = '0;
  logic            q_rd_en, busy, done, err;
  logic [QAW-1:0]  q_rd_addr;
  logic [QW-1:0]   q_rd_data = '0;
  logic [QW-1:0]   max_q, act_q;
  logic [AW-1:0]   max_act, act;
  logic [RW-1:0]   reward;

  qrow_max_select #(.NUM_STATES(NS), .NUM_ACTIONS(NA), .Q_W(QW), .R_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .state(state), .explore(explore),
    .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data),
    .busy(busy), .done(done), .err(err), .max_q(max_q), .max_act(max_act),
    .act(act), .act_q(act_q), .reward(reward)
  );

  always #5 clk = ~clk;

  logic signed [QW-1:0] mem [0:(1<<QAW)-1];
  always @(posedge clk) if (q_rd_en) q_rd_data <= mem[q_rd_addr];

  int n_tests = 0, n_fail = 0;
  logic [15:0] m_lfsr = SEED;
  int m_active = 0, m_j = 0, m_len = 0, m_base = 0, m_err = 0;
  int p_err, p_maxq, p_maxact, p_act, p_actq, p_rew;
  int e_done = 0, e_err = 0, e_maxq = 0, e_maxact = 0, e_act = 0, e_actq = 0, e_rew = 0;

  function automatic void chk(string nm, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endfunction

  function automatic logic [15:0] lfsr_next(logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Evaluate a whole accepted request from the row contents.
  function automatic void accept();
    int rnd, best, bi;
    rnd = int'(m_lfsr) % (1 << AW);
    if (rnd >= NA) rnd -= NA;
    m_active = 1;
    m_j = 0;
    if (int'(state) >= NS) begin
      m_err = 1; m_len = 1; m_base = 0;
      p_err = 1; p_maxq = 0; p_maxact = 0; p_act = 0; p_actq = 0; p_rew = 0;
    end else begin
      m_err = 0; m_len = NA + 2; m_base = int'(state) * NA;
      best = int'(mem[m_base]); bi = 0;
      for (int a = 1; a < NA; a++)
        if (int'(mem[m_base + a]) > best) begin best = int'(mem[m_base + a]); bi = a; end
      p_err = 0; p_maxq = best; p_maxact = bi;
      p_act = explore ? rnd : bi;
      p_actq = int'(mem[m_base + p_act]);
      p_rew = ((int'(state) == 35 && p_act == 1) || (int'(state) == 30 && p_act == 0)) ? 10 : 0;
    end
  endfunction

  function automatic void compare_all();
    int e_rden;
    e_rden = (m_active != 0 && m_err == 0 && m_j < NA) ? 1 : 0;
    chk("busy", int'(busy), m_active);
    chk("q_rd_en", int'(q_rd_en), e_rden);
    if (e_rden != 0) chk("q_rd_addr", int'(q_rd_addr), m_base + m_j);
    chk("done", int'(done), e_done);
    chk("err", int'(err), e_err);
    chk("max_q", int'($signed(max_q)), e_maxq);
    chk("max_act", int'(max_act), e_maxact);
    chk("act", int'(act), e_act);
    chk("act_q", int'($signed(act_q)), e_actq);
    chk("reward", int'($signed(reward)), e_rew);
  endfunction

  task automatic tick();
    if (rst_n) begin
      e_done = 0;
      if (m_active != 0) begin
        m_j++;
        if (m_j == m_len) begin
          m_active = 0; e_done = 1; e_err = p_err; e_maxq = p_maxq; e_maxact = p_maxact;
          e_act = p_act; e_actq = p_actq; e_rew = p_rew;
        end
      end else if (start) begin
        accept();
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic reset_now();
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    m_active = 0; m_err = 0; m_j = 0; m_lfsr = SEED;
    e_done = 0; e_err = 0; e_maxq = 0; e_maxact = 0; e_act = 0; e_actq = 0; e_rew = 0;
    compare_all();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_op(input int s, input bit ex, input int r0, input int r1,
                        input int r2, input int r3, output int lat);
    int row [NA];
    row = '{r0, r1, r2, r3};
    if (s < NS) for (int a = 0; a < NA; a++) mem[s * NA + a] = QW'(row[a]);
    state = SW'(s);
    explore = ex;
    start = 1'b1;
    tick();
    start = 1'b0;
    state = SW'($urandom_range(0, 63));
    explore = 1'($urandom_range(0, 1));
    lat = 0;
    while (!done && lat < 20) begin tick(); lat++; end
    chk("done_within_bound", int'(lat < 20), 1);
  endtask

  int lat, ndone, n;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << QAW); i++) mem[i] = '0;
    @(negedge clk);
    reset_now();
    tick();

    run_op(5, 0, 3, -2, 9, 1, lat);
    chk("t1_latency", lat, 6);
    chk("t1_max_q", int'($signed(max_q)), 9);
    chk("t1_max_act", int'(max_act), 2);
    chk("t1_act", int'(act), 2);
    chk("t1_act_q", int'($signed(act_q)), 9);
    chk("t1_reward", int'(reward), 0);

    run_op(35, 0, 7, 7, 7, -1, lat);
    chk("tie_max_act", int'(max_act), 0);
    chk("tie_act", int'(act), 0);
    chk("tie_reward", int'(reward), 0);
    run_op(35, 0, 0, 5, 5, 0, lat);
    chk("goal0_act", int'(act), 1);
    chk("goal0_reward", int'(reward), 10);

    run_op(7, 0, -8, -3, -5, -9, lat);
    chk("neg_max_q", int'($signed(max_q)), -3);
    chk("neg_max_act", int'(max_act), 1);

    n = 0;
    while (m_lfsr[AW-1:0] != '0 && n < 64) begin tick(); n++; end
    chk("rnd0_found", int'(n < 64), 1);
    run_op(30, 1, 4, 6, 2, 1, lat);
    chk("exp_max_q", int'($signed(max_q)), 6);
    chk("exp_max_act", int'(max_act), 1);
    chk("exp_act", int'(act), 0);
    chk("exp_act_q", int'($signed(act_q)), 4);
    chk("exp_reward", int'(reward), 10);

    run_op(40, 0, 0, 0, 0, 0, lat);
    chk("err_latency", lat, 1);
    chk("err_flag", int'(err), 1);
    chk("err_max_q", int'(max_q), 0);
    chk("err_reward", int'(reward), 0);

    // start held: back-to-back accepts, each done cycle also accepts the next one
    state = SW'(5); explore = 1'b0; start = 1'b1; ndone = 0;
    for (int k = 0; k < 21; k++) begin tick(); if (done) ndone++; end
    start = 1'b0;
    chk("held_start_dones", ndone, 3);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    tick();

    // start pulse mid-READ is ignored
    mem[12] = 16'sd1; mem[13] = 16'sd2; mem[14] = 16'sd3; mem[15] = 16'sd4;
    state = SW'(3); start = 1'b1; tick(); start = 1'b0;
    tick(); state = SW'(9); start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("midread_max_q", int'($signed(max_q)), 4);
    tick();
    chk("midread_no_second_op", int'(busy), 0);

    // reset at T0+3
    state = SW'(5); start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    reset_now();
    ndone = 0;
    for (int k = 0; k < 10; k++) begin tick(); if (done) ndone++; end
    chk("rst_no_done", ndone, 0);
    chk("rst_max_q", int'(max_q), 0);

    for (int it = 0; it < 40; it++) begin
      int s, gap, v [NA];
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      s = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 35 : 30)
                                       : int'($urandom_range(0, 41));
      for (int a = 0; a < NA; a++) v[a] = int'($urandom_range(0, 400)) - 200;
      if ($urandom_range(0, 3) == 0) v[2] = v[0];
      if (s < NS) for (int a = 0; a < NA; a++) mem[s * NA + a] = QW'(v[a]);
      state = SW'(s); explore = 1'($urandom_range(0, 1)); start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 20 && m_active != 0; k++) begin
        state = SW'($urandom_range(0, 63));
        explore = 1'($urandom_range(0, 1));
        if (k == 2 && $urandom_range(0, 9) == 0) reset_now();
        else begin
          start = ($urandom_range(0, 4) == 0);
          tick();
          start = 1'b0;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
